// File: rtl/spec_acc_engine.sv
// Spectrum accumulation engine: read-add-write address/strobe generator with a saturating adder.
// Range bins below BG_BINS are written to the background DPRAM; all others go to the accumulation DPRAM.
module spec_acc_engine #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ACC_W   = 40,
    parameter int unsigned IDX_W   = 10,
    parameter int unsigned BIN_W   = 5,
    parameter int unsigned RD_LAT  = 2,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned BG_BINS = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   acc_start,
    input  logic [CNT_W-1:0]       acc_num,
    input  logic                   data_valid_in,
    input  logic [DATA_W-1:0]      data_in,
    input  logic [IDX_W-1:0]       data_index,
    input  logic [BIN_W-1:0]       range_bin,
    input  logic                   pulse_done,
    input  logic [ACC_W-1:0]       ram_rddata,
    input  logic [ACC_W-1:0]       bg_rddata,
    output logic [BIN_W+IDX_W-1:0] rdaddr_out,
    output logic [BIN_W+IDX_W-1:0] wraddr_out,
    output logic [ACC_W-1:0]       wrdata_out,
    output logic                   DPRAM_wea,
    output logic                   DPRAM_BG_wea,
    output logic [CNT_W-1:0]       pulse_cnt,
    output logic                   busy,
    output logic                   sat_flag,
    output logic                   SPEC_Acc_Done
);

    localparam int unsigned ADDR_W = BIN_W + IDX_W;
    localparam int unsigned SUM_W  = ACC_W + 1;
    localparam int unsigned FC_W   = $clog2(RD_LAT + 2);

    typedef enum logic [1:0] {IDLE, ACC, FLUSH, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] target;
    logic [FC_W-1:0]  flush_cnt;

    // Stage 0 is the read-address stage; stage RD_LAT lines up with the returning read data.
    logic [RD_LAT:0]   pv;
    logic [RD_LAT:0]   pfirst;
    logic [RD_LAT:0]   pbg;
    logic [DATA_W-1:0] pdata [RD_LAT+1];
    logic [ADDR_W-1:0] paddr [RD_LAT+1];

    logic              accept;
    logic              is_bg;
    logic [CNT_W-1:0]  acc_num_eff;
    logic [CNT_W-1:0]  cnt_next;
    logic [ACC_W-1:0]  rd_sel;
    logic [SUM_W-1:0]  sum;
    logic [ACC_W-1:0]  result;
    logic              sat_hit;

    assign rdaddr_out = paddr[0];

    always_comb begin
        accept      = data_valid_in && (state == ACC);
        is_bg       = 32'(range_bin) < BG_BINS;
        acc_num_eff = (acc_num == '0) ? CNT_W'(1) : acc_num;
        cnt_next    = pulse_cnt + CNT_W'(1);
        rd_sel      = pbg[RD_LAT] ? bg_rddata : ram_rddata;
        sum         = SUM_W'(rd_sel) + SUM_W'(pdata[RD_LAT]);
        result      = sum[ACC_W-1:0];
        sat_hit     = 1'b0;
        // The first pulse of a run overwrites whatever the RAM holds, so no clear pass is needed.
        if (pfirst[RD_LAT]) begin
            result = ACC_W'(pdata[RD_LAT]);
        end else if (sum[ACC_W]) begin
            result  = '1;
            sat_hit = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            target        <= '0;
            flush_cnt     <= '0;
            pulse_cnt     <= '0;
            busy          <= 1'b0;
            sat_flag      <= 1'b0;
            SPEC_Acc_Done <= 1'b0;
        end else begin
            SPEC_Acc_Done <= 1'b0;
            if (pv[RD_LAT] && sat_hit) begin
                sat_flag <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (acc_start) begin
                        state     <= ACC;
                        target    <= acc_num_eff;
                        pulse_cnt <= '0;
                        sat_flag  <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                ACC: begin
                    if (pulse_done) begin
                        pulse_cnt <= cnt_next;
                        if (cnt_next == target) begin
                            state     <= FLUSH;
                            flush_cnt <= '0;
                        end
                    end
                end
                FLUSH: begin
                    // Held long enough for the last accepted beat to reach the write port.
                    if (flush_cnt == FC_W'(RD_LAT + 1)) begin
                        state         <= DONE;
                        SPEC_Acc_Done <= 1'b1;
                    end else begin
                        flush_cnt <= flush_cnt + FC_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pv           <= '0;
            pfirst       <= '0;
            pbg          <= '0;
            for (int unsigned i = 0; i <= RD_LAT; i++) begin
                pdata[i] <= '0;
                paddr[i] <= '0;
            end
            wraddr_out   <= '0;
            wrdata_out   <= '0;
            DPRAM_wea    <= 1'b0;
            DPRAM_BG_wea <= 1'b0;
        end else begin
            pv[0] <= accept;
            if (accept) begin
                paddr[0]  <= {range_bin, data_index};
                pdata[0]  <= data_in;
                pfirst[0] <= (pulse_cnt == '0);
                pbg[0]    <= is_bg;
            end
            for (int unsigned i = 1; i <= RD_LAT; i++) begin
                pv[i]     <= pv[i-1];
                pfirst[i] <= pfirst[i-1];
                pbg[i]    <= pbg[i-1];
                pdata[i]  <= pdata[i-1];
                paddr[i]  <= paddr[i-1];
            end
            DPRAM_wea    <= pv[RD_LAT] && !pbg[RD_LAT];
            DPRAM_BG_wea <= pv[RD_LAT] && pbg[RD_LAT];
            if (pv[RD_LAT]) begin
                wraddr_out <= paddr[RD_LAT];
                wrdata_out <= result;
            end
        end
    end

endmodule

// File: tb/tb_spec_acc_engine.sv
// Scoreboard bench for spec_acc_engine with ACC_W = DATA_W = 32 and behavioural DPRAMs (RD_LAT = 2).
module tb_spec_acc_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        acc_start = 1'b0;
    logic [15:0] acc_num = '0;
    logic        data_valid_in = 1'b0;
    logic [31:0] data_in = '0;
    logic [9:0]  data_index = '0;
    logic [4:0]  range_bin = '0;
    logic        pulse_done = 1'b0;
    logic [31:0] ram_rddata = '0;
    logic [31:0] bg_rddata = '0;
    logic [14:0] rdaddr_out;
    logic [14:0] wraddr_out;
    logic [31:0] wrdata_out;
    logic        DPRAM_wea;
    logic        DPRAM_BG_wea;
    logic [15:0] pulse_cnt;
    logic        busy;
    logic        sat_flag;
    logic        SPEC_Acc_Done;

    spec_acc_engine #(
        .DATA_W(32), .ACC_W(32), .IDX_W(10), .BIN_W(5),
        .RD_LAT(2), .CNT_W(16), .BG_BINS(1)
    ) dut (
        .clk(clk), .rst(rst), .acc_start(acc_start), .acc_num(acc_num),
        .data_valid_in(data_valid_in), .data_in(data_in), .data_index(data_index),
        .range_bin(range_bin), .pulse_done(pulse_done), .ram_rddata(ram_rddata),
        .bg_rddata(bg_rddata), .rdaddr_out(rdaddr_out), .wraddr_out(wraddr_out),
        .wrdata_out(wrdata_out), .DPRAM_wea(DPRAM_wea), .DPRAM_BG_wea(DPRAM_BG_wea),
        .pulse_cnt(pulse_cnt), .busy(busy), .sat_flag(sat_flag), .SPEC_Acc_Done(SPEC_Acc_Done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural DPRAMs: two-cycle read latency, garbage initial contents.
    logic [31:0] mem    [32768] = '{default: 32'hDEADBEEF};
    logic [31:0] bg_mem [32768] = '{default: 32'hDEADBEEF};
    logic [31:0] r1, bg_r1;
    always @(posedge clk) begin
        r1         <= mem[rdaddr_out];
        bg_r1      <= bg_mem[rdaddr_out];
        ram_rddata <= r1;
        bg_rddata  <= bg_r1;
        if (DPRAM_wea)    mem[wraddr_out]    <= wrdata_out;
        if (DPRAM_BG_wea) bg_mem[wraddr_out] <= wrdata_out;
    end

    typedef struct {
        int          cyc;
        logic        bg;
        logic [14:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q [$];
    int  done_q [$];
    int  checks = 0;
    int  errors = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic drv(input logic v, input logic [4:0] bin, input logic [9:0] idx,
                       input logic [31:0] d, input logic pd, input logic st, input logic [15:0] num);
        @(posedge clk);
        #1;
        data_valid_in = v;
        range_bin     = bin;
        data_index    = idx;
        data_in       = d;
        pulse_done    = pd;
        acc_start     = st;
        acc_num       = num;
    endtask

    task automatic idle(input int n);
        repeat (n) drv(1'b0, 5'd0, 10'd0, 32'd0, 1'b0, 1'b0, 16'd0);
    endtask

    task automatic start(input logic [15:0] num);
        drv(1'b0, 5'd0, 10'd0, 32'd0, 1'b0, 1'b1, num);
    endtask

    // Accepted beat: the write is due 4 cycles later, the done strobe 5 cycles after the final pulse_done.
    task automatic beat(input logic [4:0] bin, input logic [9:0] idx, input logic [31:0] d,
                        input logic [31:0] e, input logic pd, input logic last);
        wr_t w;
        drv(1'b1, bin, idx, d, pd, 1'b0, 16'd0);
        w.cyc  = cyc + 4;
        w.bg   = (bin == 5'd0);
        w.addr = {bin, idx};
        w.data = e;
        exp_q.push_back(w);
        if (last) done_q.push_back(cyc + 5);
    endtask

    task automatic end_of_run(input logic [15:0] exp_cnt, input logic exp_sat);
        idle(8);
        chk("pulse_cnt", 64'(pulse_cnt), 64'(exp_cnt));
        chk("busy_idle", 64'(busy), 64'd0);
        chk("sat_flag", 64'(sat_flag), 64'(exp_sat));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rdaddr"}, 64'(rdaddr_out), 64'd0);
        chk({tag, "_wraddr"}, 64'(wraddr_out), 64'd0);
        chk({tag, "_wrdata"}, 64'(wrdata_out), 64'd0);
        chk({tag, "_wea"}, 64'(DPRAM_wea), 64'd0);
        chk({tag, "_bg_wea"}, 64'(DPRAM_BG_wea), 64'd0);
        chk({tag, "_pulse_cnt"}, 64'(pulse_cnt), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_sat"}, 64'(sat_flag), 64'd0);
        chk({tag, "_done"}, 64'(SPEC_Acc_Done), 64'd0);
    endtask

    initial begin
        fork
            begin : monitor
                wr_t e;
                forever begin
                    @(negedge clk);
                    if (!rst && (DPRAM_wea || DPRAM_BG_wea)) begin
                        if (DPRAM_wea && DPRAM_BG_wea) begin
                            checks++;
                            errors++;
                            $display("FAIL both_strobes: got both high at cycle %0d, expected one", cyc);
                        end else if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_write: got strobe addr %0h at cycle %0d, expected none",
                                     wraddr_out, cyc);
                        end else begin
                            e = exp_q.pop_front();
                            chk("wr_cycle", 64'(cyc), 64'(e.cyc));
                            chk("wr_bg", 64'(DPRAM_BG_wea), 64'(e.bg));
                            chk("wr_addr", 64'(wraddr_out), 64'(e.addr));
                            chk("wr_data", 64'(wrdata_out), 64'(e.data));
                        end
                    end
                    if (!rst && SPEC_Acc_Done) begin
                        if (done_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
                        end else begin
                            chk("done_cycle", 64'(cyc), 64'(done_q.pop_front()));
                        end
                    end
                end
            end
        join_none

        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;
        idle(2);

        // Single run: pulse 0 ignores the garbage RAM contents.
        start(16'd1);
        for (int i = 0; i < 1024; i++) begin
            beat(5'd3, 10'(i), 32'(i), 32'(i), (i == 1023), (i == 1023));
            if (i == 10) chk("busy_run", 64'(busy), 64'd1);
        end
        end_of_run(16'd1, 1'b0);

        // Four pulses of 5 accumulate to 20.
        start(16'd4);
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 8; i++)
                beat(5'd2, 10'(i), 32'd5, 32'(5 * (p + 1)), (i == 7), (i == 7 && p == 3));
            idle(2);
        end
        end_of_run(16'd4, 1'b0);
        for (int i = 0; i < 8; i++) chk("acc_ram", 64'(mem[{5'd2, 10'(i)}]), 64'd20);

        // Bin 0 goes to the background RAM, bin 1 to the accumulation RAM.
        start(16'd1);
        for (int i = 0; i < 4; i++) beat(5'd0, 10'(i), 32'd7, 32'd7, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) beat(5'd1, 10'(i), 32'd9, 32'd9, (i == 3), (i == 3));
        end_of_run(16'd1, 1'b0);
        chk("bg_ram", 64'(bg_mem[15'h003]), 64'd7);
        chk("acc_ram_bin1", 64'(mem[15'h403]), 64'd9);

        // Saturation: 0xFFFFFFF0 + 0x20 clamps; 0x10 + 0x20 does not.
        start(16'd2);
        beat(5'd4, 10'd0, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 1'b0, 1'b0);
        beat(5'd4, 10'd1, 32'h10, 32'h10, 1'b1, 1'b0);
        idle(6);
        chk("sat_pulse0", 64'(sat_flag), 64'd0);
        beat(5'd4, 10'd1, 32'h20, 32'h30, 1'b0, 1'b0);
        beat(5'd4, 10'd0, 32'h20, 32'hFFFF_FFFF, 1'b1, 1'b1);
        end_of_run(16'd2, 1'b1);

        // Gating: beats in IDLE dropped, acc_num=0 acts as 1, acc_start while busy ignored.
        drv(1'b1, 5'd5, 10'd0, 32'd1, 1'b1, 1'b0, 16'd0);
        drv(1'b1, 5'd5, 10'd1, 32'd1, 1'b0, 1'b0, 16'd0);
        start(16'd0);
        beat(5'd5, 10'd0, 32'd3, 32'd3, 1'b0, 1'b0);
        chk("sat_cleared", 64'(sat_flag), 64'd0);
        drv(1'b1, 5'd5, 10'd1, 32'd3, 1'b0, 1'b1, 16'd7);
        begin
            wr_t w;
            w.cyc = cyc + 4; w.bg = 1'b0; w.addr = {5'd5, 10'd1}; w.data = 32'd3;
            exp_q.push_back(w);
        end
        beat(5'd5, 10'd2, 32'd3, 32'd3, 1'b1, 1'b1);
        drv(1'b1, 5'd5, 10'd3, 32'd3, 1'b1, 1'b1, 16'd3);
        drv(1'b1, 5'd5, 10'd4, 32'd3, 1'b0, 1'b0, 16'd0);
        end_of_run(16'd1, 1'b0);

        // Reset two cycles after an accepted final beat: nothing may emerge afterwards.
        start(16'd1);
        drv(1'b1, 5'd6, 10'd9, 32'd11, 1'b1, 1'b0, 16'd0);
        idle(1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        data_valid_in = 1'b0;
        pulse_done = 1'b0;
        #1;
        chk_all_zero("midreset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(10);
        chk("post_reset_cnt", 64'(pulse_cnt), 64'd0);

        chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
        chk("done_q_empty", 64'(done_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spec_acc_engine.md
Name: spec_acc_engine

Overview:
- Parametrised successor to the spectrum-accumulation address/strobe generator.
- Accumulates per-range-bin FFT power spectra over a programmable number of pulses into an external DPRAM using read-add-write, with a saturating adder on the datapath.
- Range bins below a programmable boundary are routed to the background DPRAM.
- Sits between the FFT magnitude stage and the accumulation/background DPRAMs. Supplies addresses, write data, write strobes and a done strobe to post-processing.

Parameters:
- DATA_W, 32, width of the incoming spectral sample.
- ACC_W, 40, accumulator and DPRAM word width; must be >= DATA_W.
- IDX_W, 10, FFT bin index width (2^IDX_W points).
- BIN_W, 5, range-bin index width.
- RD_LAT, 2, DPRAM read latency in cycles, from rdaddr_out to ram_rddata (>= 1).
- CNT_W, 16, pulse-count width.
- BG_BINS, 1, range bins 0..BG_BINS-1 go to the background DPRAM.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- acc_start  in  1  one-cycle start pulse; loads acc_num
- acc_num  in  CNT_W  pulses to accumulate; 0 is treated as 1
- data_valid_in  in  1  spectral sample valid
- data_in  in  DATA_W  spectral sample (unsigned)
- data_index  in  IDX_W  FFT bin of data_in
- range_bin  in  BIN_W  range bin of data_in, 0-based
- pulse_done  in  1  one-cycle strobe after the last sample of a pulse
- ram_rddata  in  ACC_W  accumulation DPRAM read data
- bg_rddata  in  ACC_W  background DPRAM read data
- rdaddr_out  out  BIN_W+IDX_W  read address {range_bin, data_index}
- wraddr_out  out  BIN_W+IDX_W  write address
- wrdata_out  out  ACC_W  write data (shared by both DPRAMs)
- DPRAM_wea  out  1  accumulation DPRAM write enable
- DPRAM_BG_wea  out  1  background DPRAM write enable
- pulse_cnt  out  CNT_W  pulses completed in the current run
- busy  out  1  high in any state other than IDLE
- sat_flag  out  1  sticky: an addition saturated in the current run
- SPEC_Acc_Done  out  1  one-cycle end-of-run strobe

Behaviour:
- Reset: all outputs and internal pipeline registers go to 0. FSM goes to IDLE. In-flight writes are discarded, and no write strobe fires after reset release until new accepted data arrives.
- FSM: IDLE -> ACC on acc_start. ACC -> FLUSH when the pulse_done that makes pulse_cnt equal max(acc_num,1) arrives. FLUSH lasts exactly RD_LAT+2 cycles, then goes to DONE. DONE lasts 1 cycle with SPEC_Acc_Done=1, then goes to IDLE.
- acc_start outside IDLE is ignored.
- acc_start in IDLE clears pulse_cnt and sat_flag and latches max(acc_num,1).
- Accept: a beat is accepted only when data_valid_in=1 and state=ACC. Valid beats in IDLE, FLUSH or DONE are dropped and produce no strobes.
- pulse_done is honoured only in ACC. A beat accepted in the same cycle as pulse_done belongs to the ending pulse.
- Pipeline for an accepted beat at cycle t:
  - t+1: rdaddr_out = {range_bin, data_index}. rdaddr_out holds its value when no beat is accepted.
  - t+1+RD_LAT: the read data is sampled.
  - t+RD_LAT+2: wraddr_out = the same address, wrdata_out = result, and exactly one write strobe is high for one cycle.
  - Input-to-write latency is RD_LAT+2. Full throughput of one beat per cycle.
- Strobe select:
  - range_bin < BG_BINS: DPRAM_BG_wea, with bg_rddata as the addend.
  - otherwise: DPRAM_wea, with ram_rddata as the addend.
  - Never both high in the same cycle.
- Arithmetic:
  - Pulse 0 of a run (pulse_cnt=0 when the beat was accepted): result = zero-extended data_in; read data is ignored. This replaces any RAM clear.
  - Later pulses: result = read data + zero-extended data_in, computed at ACC_W+1 bits.
  - If the carry-out is set, result = all ones and sat_flag is set; it stays set until the next acc_start or reset.
- Read-after-write to the same address within RD_LAT+2 cycles is not forwarded. The upstream stream guarantees unique addresses within a pulse.
- pulse_cnt increments on each honoured pulse_done and holds its final value through IDLE.
- FLUSH guarantees the last write completes before SPEC_Acc_Done.
- Reset during FLUSH: no done strobe is issued.

Test Plan:
- Single run: acc_num=1, one pulse with range_bin=3, data_index 0..1023, data_in=index. DPRAM_wea fires 1024 times, first at 4 cycles after the first valid (RD_LAT=2). wrdata = index regardless of RAM contents. DPRAM_BG_wea never fires. SPEC_Acc_Done fires once, 4 cycles after the FLUSH entry.
- Accumulate: acc_num=4, same 8-sample pulse of data_in=5 repeated 4 times with a RAM model. Final RAM = 20 at each address. pulse_cnt=4. Exactly one done strobe.
- Background split: BG_BINS=1, range bins 0 and 1, 4 samples each. DPRAM_BG_wea fires for bin 0 at addresses 0x000-0x003. DPRAM_wea fires for bin 1 at 0x400-0x403. No overlap.
- Saturation: ACC_W=DATA_W=32, preload RAM 0xFFFFFFF0, second pulse data_in=0x20. wrdata = 0xFFFFFFFF and sat_flag=1. Next acc_start clears sat_flag.
- Gating: valid beats in IDLE and acc_start while busy -> no strobes and the run is unaffected. acc_num=0 -> behaves as 1.
- Reset mid-pipeline: assert rst 2 cycles after a valid beat. All outputs go to 0 immediately. No write strobe and no done strobe after release.
